// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants that the board top also uses.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W         = 16;
    localparam int DEFAULT_REPEAT_CYCLES = 5000000;
    localparam int DEFAULT_REPEAT_W      = 23;

    // The debounced level is high in every state that follows an accepted press.
    function automatic logic is_pressed_level(input btn_state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops clear
// to 0 on the active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_pulse_debouncer.sv
// Synchronises and debounces a raw push-button, exporting the clean level and
// a one-cycle enable pulse per press. Auto-repeat: BTN_PULSE_DEBOUNCER_REPEAT_EN.
module btn_pulse_debouncer
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int REPEAT_W      = DEFAULT_REPEAT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic en_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if ((STABLE_CYCLES < 2) || (longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_stable
        $error("STABLE_CYCLES must lie in 2..2^CNT_W-1");
    end

    logic       s_in;
    btn_state_t state;
    btn_state_t state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic       press_pulse;
    logic       en_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s_in)
    );

    // A bounce in either wait state falls back to the previous stable state and
    // restarts qualification from zero.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        press_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (s_in) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_in) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next  = PRESSED;
                    cnt_next    = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s_in) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s_in) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BTN_PULSE_DEBOUNCER_REPEAT_EN

    localparam logic [REPEAT_W-1:0] RPT_LAST = REPEAT_W'(REPEAT_CYCLES - 1);

    if ((REPEAT_CYCLES < 1) || (longint'(REPEAT_CYCLES) > ((longint'(1) << REPEAT_W) - 1))) begin : g_bad_repeat
        $error("REPEAT_CYCLES must fit in REPEAT_W");
    end

    logic [REPEAT_W-1:0] rcnt;
    logic [REPEAT_W-1:0] rcnt_next;
    logic                repeat_fire;

    // The repeat timer only advances while the press is held steadily; the
    // first cycle of every (re)entry into PRESSED starts it from zero.
    always_comb begin
        rcnt_next   = rcnt;
        repeat_fire = 1'b0;
        if ((state == PRESSED) && (state_next == PRESSED)) begin
            if (rcnt == RPT_LAST) begin
                repeat_fire = 1'b1;
                rcnt_next   = '0;
            end else begin
                rcnt_next = rcnt + 1'b1;
            end
        end else if ((state == RELEASE_WAIT) && (state_next == RELEASE_WAIT)) begin
            rcnt_next = rcnt;
        end else begin
            rcnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_next;
        end
    end

    assign en_next = press_pulse | repeat_fire;

`else

    if ((REPEAT_W < 1) || (REPEAT_CYCLES < 1)) begin : g_bad_repeat
        $error("REPEAT_CYCLES and REPEAT_W must be positive");
    end

    assign en_next = press_pulse;

`endif

    // Outputs are registered from the next state so they change on the same
    // edge the FSM commits its decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            en_pulse  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            btn_level <= is_pressed_level(state_next);
            en_pulse  <= en_next;
        end
    end

endmodule

// File: tb/tb_btn_pulse_debouncer.sv
// Self-checking bench for btn_pulse_debouncer: hand sequences, a vector table
// and random stimulus against a run-length reference model.
module tb_btn_pulse_debouncer;

    localparam int STABLE = 4;
    localparam int REPEAT = 10;
    localparam int LAT    = STABLE + 3;

`ifdef BTN_PULSE_DEBOUNCER_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic en_pulse;

    always #5 clk = ~clk;

    btn_pulse_debouncer #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (16),
        .REPEAT_CYCLES (REPEAT),
        .REPEAT_W      (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .en_pulse  (en_pulse)
    );

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: the level flips once the synchronised input has
    // disagreed with it for STABLE+1 consecutive samples.
    logic m_sync [2];
    logic m_level;
    logic m_pulse;
    int   m_run;
    int   m_rep;
    bit   compare_model = 1'b0;

    logic [3:0] chain_count;
    int         pulse_pos [$];

    typedef struct {
        int   mode;
        int   width;
        int   exp_pulses;
        logic exp_dip;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelStep(input logic b, input logic r);
        logic sample;
        if (!r) begin
            m_sync[0] = 1'b0;
            m_sync[1] = 1'b0;
            m_level   = 1'b0;
            m_pulse   = 1'b0;
            m_run     = 0;
            m_rep     = 0;
        end else begin
            sample    = m_sync[1];
            m_sync[1] = m_sync[0];
            m_sync[0] = b;
            m_pulse   = 1'b0;
            if (sample != m_level) begin
                m_run++;
                m_rep = 0;
                if (m_run == STABLE + 1) begin
                    m_level = sample;
                    m_run   = 0;
                    if (m_level) m_pulse = 1'b1;
                end
            end else begin
                if (m_level && REPEAT_ON) begin
                    if (m_run > 0) begin
                        m_rep = 0;
                    end else if (m_rep == REPEAT - 1) begin
                        m_pulse = 1'b1;
                        m_rep   = 0;
                    end else begin
                        m_rep++;
                    end
                end
                m_run = 0;
            end
        end
    endtask

    // One clock: drive the button, let the edge happen, sample 1 time unit later.
    task automatic applyStimulus(input logic b);
        btn_in = b;
        @(posedge clk);
        modelStep(b, rst);
        #1;
        if (en_pulse) chain_count = chain_count + 4'd1;
        if (compare_model) begin
            checkOutput("model_level", int'(btn_level), int'(m_level));
            checkOutput("model_pulse", int'(en_pulse), int'(m_pulse));
        end
    endtask

    task automatic runHold(input logic b, input int n, output int first_pulse,
                           output int pulses, output int first_change, output logic saw_low);
        logic start_level;
        start_level  = btn_level;
        first_pulse  = -1;
        pulses       = 0;
        first_change = -1;
        saw_low      = 1'b0;
        pulse_pos.delete();
        for (int i = 1; i <= n; i++) begin
            applyStimulus(b);
            if (en_pulse) begin
                pulses++;
                pulse_pos.push_back(i);
                if (first_pulse < 0) first_pulse = i;
            end
            if ((btn_level != start_level) && (first_change < 0)) first_change = i;
            if (!btn_level) saw_low = 1'b1;
        end
    endtask

    initial begin
        int   fp, np, fc, tot;
        logic lo, dip, bad;

        vecs[0] = '{0, 1, 0, 1'b0};
        vecs[1] = '{0, 2, 0, 1'b0};
        vecs[2] = '{0, 4, 0, 1'b0};
        vecs[3] = '{0, 5, 1, 1'b0};
        vecs[4] = '{0, 9, 1, 1'b0};
        vecs[5] = '{1, 1, 1, 1'b0};
        vecs[6] = '{1, 3, 1, 1'b0};
        vecs[7] = '{1, 4, 1, 1'b0};
        vecs[8] = '{1, 5, 2, 1'b1};
        vecs[9] = '{1, 8, 2, 1'b1};

        // Reset with the button held: outputs stay low, then one qualified press.
        btn_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_level_async", int'(btn_level), 0);
        checkOutput("reset_pulse_async", int'(en_pulse), 0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1);
            if (btn_level || en_pulse) bad = 1'b1;
        end
        checkOutput("reset_held_outputs_low", int'(bad), 0);
        rst = 1'b1;
        runHold(1'b1, 12, fp, np, fc, lo);
        checkOutput("reset_release_pulse_cycle", fp, LAT);
        checkOutput("reset_release_pulse_count", np, 1);
        checkOutput("reset_release_level", int'(btn_level), 1);

        // Clean press from idle.
        runHold(1'b0, 20, fp, np, fc, lo);
        checkOutput("release_level_low", int'(btn_level), 0);
        runHold(1'b1, 12, fp, np, fc, lo);
        checkOutput("clean_press_pulse_cycle", fp, LAT);
        checkOutput("clean_press_pulse_count", np, 1);
        checkOutput("clean_press_level_rise", fc, LAT);

        // Bouncing press: 1,0,1,0 for two cycles each, then steady high.
        runHold(1'b0, 20, fp, np, fc, lo);
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            runHold(((k % 2) == 0) ? 1'b1 : 1'b0, 2, fp, np, fc, lo);
            tot += np;
        end
        checkOutput("bounce_no_early_pulse", tot, 0);
        runHold(1'b1, 12, fp, np, fc, lo);
        checkOutput("bounce_pulse_cycle", fp, LAT);
        checkOutput("bounce_pulse_count", np, 1);

        // Release bounce while pressed, then a clean release.
        runHold(1'b0, 3, fp, np, fc, lo);
        tot = np;
        dip = lo;
        runHold(1'b1, 6, fp, np, fc, lo);
        tot += np;
        dip |= lo;
        checkOutput("release_bounce_no_pulse", tot, 0);
        checkOutput("release_bounce_level_kept", int'(dip), 0);
        runHold(1'b0, 20, fp, np, fc, lo);
        checkOutput("clean_release_fall_cycle", fc, LAT);

        // Reset during PRESS_WAIT, then during PRESSED, with the button held.
        runHold(1'b1, 4, fp, np, fc, lo);
        rst = 1'b0;
        #1;
        checkOutput("reset_mid_wait_level", int'(btn_level), 0);
        runHold(1'b1, 3, fp, np, fc, lo);
        checkOutput("reset_mid_wait_no_pulse", np, 0);
        rst = 1'b1;
        runHold(1'b1, 12, fp, np, fc, lo);
        checkOutput("reset_mid_wait_requalify", fp, LAT);
        rst = 1'b0;
        #1;
        checkOutput("reset_mid_pressed_level", int'(btn_level), 0);
        checkOutput("reset_mid_pressed_pulse", int'(en_pulse), 0);
        runHold(1'b1, 3, fp, np, fc, lo);
        rst = 1'b1;
        runHold(1'b1, 12, fp, np, fc, lo);
        checkOutput("reset_mid_pressed_requalify", fp, LAT);
        checkOutput("reset_mid_pressed_count", np, 1);

        // Vector table: press glitches (mode 0) and release glitches (mode 1).
        foreach (vecs[v]) begin
            runHold(1'b0, 20, fp, np, fc, lo);
            tot = 0;
            dip = 1'b0;
            if (vecs[v].mode == 0) begin
                runHold(1'b1, vecs[v].width, fp, np, fc, lo);
                tot += np;
                runHold(1'b0, 20, fp, np, fc, lo);
                tot += np;
            end else begin
                runHold(1'b1, 12, fp, np, fc, lo);
                tot += np;
                runHold(1'b0, vecs[v].width, fp, np, fc, lo);
                tot += np;
                dip |= lo;
                runHold(1'b1, 10, fp, np, fc, lo);
                tot += np;
                dip |= lo;
                runHold(1'b0, 20, fp, np, fc, lo);
                tot += np;
            end
            checkOutput($sformatf("vec%0d_pulses", v), tot, vecs[v].exp_pulses);
            checkOutput($sformatf("vec%0d_dip", v), int'(dip), int'(vecs[v].exp_dip));
        end

        // Chain into a 4-bit counter: twelve clean presses.
        chain_count = 4'd0;
        for (int k = 0; k < 12; k++) begin
            runHold(1'b1, 12, fp, np, fc, lo);
            runHold(1'b0, 12, fp, np, fc, lo);
        end
        checkOutput("chain_counter", int'(chain_count), 12);

        // Long hold: auto-repeat pulses only when the feature is built in.
        runHold(1'b1, 40, fp, np, fc, lo);
        if (REPEAT_ON) begin
            checkOutput("hold_pulse_count", np, 4);
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("hold_pulse_%0d", k),
                            (k < pulse_pos.size()) ? pulse_pos[k] : -1, LAT + k * REPEAT);
            end
        end else begin
            checkOutput("hold_pulse_count", np, 1);
            checkOutput("hold_pulse_0", fp, LAT);
        end
        runHold(1'b0, 20, fp, np, fc, lo);

        // Random segments compared cycle by cycle against the model.
        compare_model = 1'b1;
        for (int seg = 0; seg < 500; seg++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                applyStimulus(b);
                applyStimulus(b);
                rst = 1'b1;
            end
            for (int c = 0; c < len; c++) applyStimulus(b);
        end
        compare_model = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
